// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between NREQ write-back sources.
// Each source pushes {addr, data} into its own DEPTH-entry FIFO. A round-robin
// arbiter pops at most one FIFO head per cycle onto the registered rf_* port.
// Writes to x0 are popped but suppressed (rf_we stays low). pend_mask reports
// every register with a write still in flight, so decode can stall on RAW.
//
// Optional feature (define REGWB_STALL_CNT_EN):
//   adds output stall_cnt, one saturating 16-bit counter per requester that
//   counts cycles with req_valid[i] && !req_ready[i]. Cleared by reset/flush.
//
// Ports
//   clk        in   1          clock, all state updates on posedge
//   rst_n      in   1          asynchronous active-low reset
//   flush      in   1          synchronous flush, discards all pending writes
//   req_valid  in   NREQ       requester i has a write
//   req_ready  out  NREQ       FIFO i can accept (!full_i && !flush)
//   req_addr   in   NREQ*AW    requester i destination at [i*AW +: AW]
//   req_data   in   NREQ*DW    requester i data at [i*DW +: DW]
//   rf_we      out  1          registered register-file write enable
//   rf_waddr   out  AW         registered write address
//   rf_wdata   out  DW         registered write data
//   pend_mask  out  2**AW      bit r set while a write to r is queued or on rf_*
//   idle       out  1          all FIFOs empty and rf_we == 0
//   stall_cnt  out  NREQ*16    (REGWB_STALL_CNT_EN only) per-requester stall counts
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NREQ  = 2,
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic [2**AW-1:0]     pend_mask,
    output logic                 idle
`ifdef REGWB_STALL_CNT_EN
    ,
    output logic [NREQ*16-1:0]   stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // FIFO storage and bookkeeping, one set per requester
    logic [AW-1:0] mem_addr [NREQ][DEPTH];
    logic [DW-1:0] mem_data [NREQ][DEPTH];
    logic [PW-1:0] wr_ptr   [NREQ];
    logic [PW-1:0] rd_ptr   [NREQ];
    logic [CW-1:0] count    [NREQ];

    logic [RW-1:0]   rr_ptr;
    logic [NREQ-1:0] non_empty;
    logic [NREQ-1:0] full;
    logic [NREQ-1:0] push;
    logic [NREQ-1:0] pop;
    logic            found;
    logic [RW-1:0]   winner;
    logic [RW-1:0]   cand;
    logic [AW-1:0]   head_addr;
    logic [DW-1:0]   head_data;
    logic [PW-1:0]   slot_off;

    // ---------------------------------------------------------------------
    // FIFO status and push handshake
    // ---------------------------------------------------------------------
    // NOTE: every signal written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        non_empty = '0;
        full      = '0;
        req_ready = '0;
        push      = '0;
        for (int i = 0; i < NREQ; i++) begin
            non_empty[i] = (count[i] != '0);
            full[i]      = (count[i] == CW'(DEPTH));
            req_ready[i] = !full[i] && !flush;
            push[i]      = req_valid[i] && req_ready[i];
        end
    end

    // ---------------------------------------------------------------------
    // Round-robin pick: first non-empty FIFO at or after rr_ptr (mod NREQ)
    // ---------------------------------------------------------------------
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        pop    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = RW'((int'(rr_ptr) + k) % NREQ);
            if (!found && non_empty[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        if (found && !flush) begin
            pop[winner] = 1'b1;
        end
    end

    assign head_addr = mem_addr[winner][rd_ptr[winner]];
    assign head_data = mem_data[winner][rd_ptr[winner]];

    // ---------------------------------------------------------------------
    // FIFO pointers and occupancy (pointers wrap naturally at DEPTH)
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (flush) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    count[i]  <= '0;
                end else begin
                    if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    // push and pop at the same edge leave occupancy unchanged
                    count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
                end
            end
        end
    end

    // NOTE: the FIFO storage has no reset; an entry is only ever read while
    // the occupancy counter marks it valid, so its power-up value is unused.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (push[i]) begin
                mem_addr[i][wr_ptr[i]] <= req_addr[i*AW +: AW];
                mem_data[i][wr_ptr[i]] <= req_data[i*DW +: DW];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registered write port and round-robin pointer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rr_ptr   <= '0;
        end else if (flush) begin
            rf_we  <= 1'b0;
            rr_ptr <= '0;
        end else if (found) begin
            // x0 writes are consumed but never presented to the register file
            rf_we    <= (head_addr != '0);
            rf_waddr <= head_addr;
            rf_wdata <= head_data;
            rr_ptr   <= RW'((int'(winner) + 1) % NREQ);
        end else begin
            rf_we <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Pending-write mask and idle
    // ---------------------------------------------------------------------
    always_comb begin
        pend_mask = '0;
        slot_off  = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                // slot j is live when its distance from the head is below count
                slot_off = PW'(j) - rd_ptr[i];
                if ({1'b0, slot_off} < count[i]) begin
                    pend_mask[mem_addr[i][j]] = 1'b1;
                end
            end
        end
        if (rf_we) begin
            pend_mask[rf_waddr] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    assign idle = (non_empty == '0) && !rf_we;

`ifdef REGWB_STALL_CNT_EN
    // ---------------------------------------------------------------------
    // Saturating per-requester stall counters
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (flush) begin
                    stall_cnt[i*16 +: 16] <= '0;
                end else if (req_valid[i] && !req_ready[i] &&
                             stall_cnt[i*16 +: 16] != 16'hFFFF) begin
                    stall_cnt[i*16 +: 16] <= stall_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Self-checking bench for regfile_wb_arbiter (NREQ=2, DEPTH=2, AW=5, DW=32).
// Inputs are driven 1 time unit after posedge, outputs sampled on negedge.
// Part 1 replays a hand-computed vector table from reset. The remaining parts
// compare the DUT every cycle against a queue-based model: in-order hold
// traffic, randomized traffic with flushes, and an asynchronous mid-stream
// reset.
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    localparam int NREQ  = 2;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pend_mask;
    logic        idle;
`ifdef REGWB_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.NREQ(2), .DEPTH(2), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pend_mask (pend_mask),
        .idle      (idle)
`ifdef REGWB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: one queue per requester, a rotating priority index,
    // and the last value presented on the write port.
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq [NREQ][$];
    int          m_rr;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) mq[i].delete();
        m_rr    = 0;
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    function automatic logic [1:0] model_ready(input logic fl);
        logic [1:0] r;
        for (int i = 0; i < NREQ; i++) r[i] = (mq[i].size() < DEPTH) && !fl;
        return r;
    endfunction

    function automatic logic [31:0] model_pend();
        logic [31:0] pm = '0;
        for (int i = 0; i < NREQ; i++)
            for (int j = 0; j < mq[i].size(); j++) pm[mq[i][j].a] = 1'b1;
        if (m_we) pm[m_waddr] = 1'b1;
        pm[0] = 1'b0;
        return pm;
    endfunction

    function automatic logic model_idle();
        logic any = 1'b0;
        for (int i = 0; i < NREQ; i++) if (mq[i].size() != 0) any = 1'b1;
        return !any && !m_we;
    endfunction

    // Advance the model across one clock edge with the given inputs.
    task automatic model_step(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                              input logic [4:0] a1, input logic [31:0] d1, input logic fl);
        logic [1:0] rdy = model_ready(fl);
        bit         got = 0;
        ent_t       e;
        if (fl) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NREQ; k++) begin
            int idx = (m_rr + k) % NREQ;
            if (!got && mq[idx].size() > 0) begin
                e       = mq[idx].pop_front();
                m_we    = (e.a != 0);
                m_waddr = e.a;
                m_wdata = e.d;
                m_rr    = (idx + 1) % NREQ;
                got     = 1;
            end
        end
        if (!got) m_we = 1'b0;
        if (v[0] && rdy[0]) begin e.a = a0; e.d = d0; mq[0].push_back(e); end
        if (v[1] && rdy[1]) begin e.a = a1; e.d = d1; mq[1].push_back(e); end
    endtask

    // Drive one cycle, compare DUT against the model on negedge, step both.
    task automatic apply_cycle(input string tag, input logic [1:0] v,
                               input logic [4:0] a0, input logic [31:0] d0,
                               input logic [4:0] a1, input logic [31:0] d1,
                               input logic fl, output logic [1:0] rdy);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        flush     = fl;
        @(negedge clk);
        rdy = req_ready;
        check({tag, " req_ready"}, req_ready, model_ready(fl));
        check({tag, " rf_we"}, rf_we, m_we);
        if (m_we) begin
            check({tag, " rf_waddr"}, rf_waddr, m_waddr);
            check({tag, " rf_wdata"}, rf_wdata, m_wdata);
        end
        check({tag, " pend_mask"}, pend_mask, model_pend());
        check({tag, " idle"}, idle, model_idle());
        model_step(v, a0, d0, a1, d1, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------------------------------------------------------------
    // Directed vector table: inputs for the cycle and the outputs expected
    // on the negedge of that same cycle (before its closing posedge).
    // ---------------------------------------------------------------------
    typedef struct {
        logic [1:0]  valid;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        fl;
        logic [1:0]  exp_ready;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_pend;
        logic        exp_idle;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                                input logic [4:0] a1, input logic [31:0] d1, input logic fl,
                                input logic [1:0] er, input logic ew, input logic [4:0] ea,
                                input logic [31:0] ed, input logic [31:0] ep, input logic ei);
        vec_t t;
        t.valid = v;  t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1; t.fl = fl;
        t.exp_ready = er; t.exp_we = ew; t.exp_waddr = ea; t.exp_wdata = ed;
        t.exp_pend = ep;  t.exp_idle = ei;
        return t;
    endfunction

    vec_t vecs [18];

    initial begin
        logic [1:0]  rdy;
        int          n0, n1, stall1, writes, last_src;
        bit          have_prev;
        logic [1:0]  v;
        logic [4:0]  ra0, ra1;

        // single push from reset, x0 drop, same-cycle pair, flush with traffic
        vecs[0]  = mk(2'b01, 5'd3,  32'hA5A5_0001, 5'd0,  32'h0,   0, 2'b11, 0, 5'd0, 32'h0,          32'h0000_0000, 1);
        vecs[1]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,   0, 2'b11, 0, 5'd0, 32'h0,          32'h0000_0008, 0);
        vecs[2]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,   0, 2'b11, 1, 5'd3, 32'hA5A5_0001,  32'h0000_0008, 0);
        vecs[3]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,   1, 2'b00, 0, 5'd0, 32'h0,          32'h0000_0000, 1);
        vecs[4]  = mk(2'b11, 5'd4,  32'h11,        5'd5,  32'h22,  0, 2'b11, 0, 5'd0, 32'h0,          32'h0000_0000, 1);
        vecs[5]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,   0, 2'b11, 0, 5'd0, 32'h0,          32'h0000_0030, 0);
        vecs[6]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,   0, 2'b11, 1, 5'd4, 32'h11,         32'h0000_0030, 0);
        vecs[7]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,   0, 2'b11, 1, 5'd5, 32'h22,         32'h0000_0020, 0);
        vecs[8]  = mk(2'b01, 5'd0,  32'hFFFF_FFFF, 5'd0,  32'h0,   0, 2'b11, 0, 5'd0, 32'h0,          32'h0000_0000, 1);
        vecs[9]  = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,   0, 2'b11, 0, 5'd0, 32'h0,          32'h0000_0000, 0);
        vecs[10] = mk(2'b11, 5'd6,  32'h60,        5'd7,  32'h70,  0, 2'b11, 0, 5'd0, 32'h0,          32'h0000_0000, 1);
        vecs[11] = mk(2'b11, 5'd8,  32'h80,        5'd9,  32'h90,  0, 2'b11, 0, 5'd0, 32'h0,          32'h0000_00C0, 0);
        vecs[12] = mk(2'b11, 5'd10, 32'hA0,        5'd11, 32'hB0,  0, 2'b10, 1, 5'd7, 32'h70,         32'h0000_03C0, 0);
        vecs[13] = mk(2'b11, 5'd12, 32'hC0,        5'd13, 32'hD0,  0, 2'b01, 1, 5'd6, 32'h60,         32'h0000_0B40, 0);
        vecs[14] = mk(2'b11, 5'd14, 32'hE0,        5'd15, 32'hF0,  0, 2'b10, 1, 5'd9, 32'h90,         32'h0000_1B00, 0);
        vecs[15] = mk(2'b11, 5'd16, 32'h100,       5'd17, 32'h110, 1, 2'b00, 1, 5'd8, 32'h80,         32'h0000_9900, 0);
        vecs[16] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,   0, 2'b11, 0, 5'd0, 32'h0,          32'h0000_0000, 1);
        vecs[17] = mk(2'b00, 5'd0,  32'h0,         5'd0,  32'h0,   0, 2'b11, 0, 5'd0, 32'h0,          32'h0000_0000, 1);

        // ---- reset state, sampled while rst_n is held low ----
        rst_n     = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        #3;
        check("reset rf_we", rf_we, 1'b0);
        check("reset rf_waddr", rf_waddr, 5'd0);
        check("reset rf_wdata", rf_wdata, 32'h0);
        check("reset pend_mask", pend_mask, 32'h0);
        check("reset idle", idle, 1'b1);
        do_reset();

        // ---- directed vector table ----
        for (int i = 0; i < 18; i++) begin
            req_valid = vecs[i].valid;
            req_addr  = {vecs[i].a1, vecs[i].a0};
            req_data  = {vecs[i].d1, vecs[i].d0};
            flush     = vecs[i].fl;
            @(negedge clk);
            check($sformatf("vec%0d req_ready", i), req_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d rf_we", i), rf_we, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d rf_waddr", i), rf_waddr, vecs[i].exp_waddr);
                check($sformatf("vec%0d rf_wdata", i), rf_wdata, vecs[i].exp_wdata);
            end
            check($sformatf("vec%0d pend_mask", i), pend_mask, vecs[i].exp_pend);
            check($sformatf("vec%0d idle", i), idle, vecs[i].exp_idle);
            @(posedge clk);
            #1;
        end

        // ---- both requesters held valid: writes alternate, req1 stalls ----
        do_reset();
        n0 = 0; n1 = 0; stall1 = 0; have_prev = 0; last_src = 0;
        for (int c = 0; c < 6; c++) begin
            apply_cycle("hold", 2'b11, 5'(10 + n0), 32'h1000 + n0, 5'(20 + n1), 32'h2000 + n1, 0, rdy);
            if (!rdy[1]) stall1++;
            if (rdy[0]) n0++;
            if (rdy[1]) n1++;
            if (rf_we) begin
                if (have_prev)
                    check("hold alternation", (rf_waddr >= 5'd20) ? 1 : 0, (last_src == 0) ? 1 : 0);
                last_src  = (rf_waddr >= 5'd20) ? 1 : 0;
                have_prev = 1;
            end
        end
        check("hold req1 stalled", (stall1 > 0) ? 1'b1 : 1'b0, 1'b1);
`ifdef REGWB_STALL_CNT_EN
        check("hold stall_cnt[1]", stall_cnt[31:16], 16'(stall1));
        check("hold stall_cnt[0]", stall_cnt[15:0], 16'd0);
`endif
        for (int c = 0; c < 6; c++)
            apply_cycle("drain", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, rdy);

        // ---- randomized traffic including x0 and occasional flush ----
        for (int c = 0; c < 400; c++) begin
            v   = 2'($urandom_range(0, 3));
            ra0 = 5'($urandom_range(0, 31));
            ra1 = 5'($urandom_range(0, 31));
            apply_cycle($sformatf("rand%0d", c), v, ra0, $urandom, ra1, $urandom,
                        ($urandom_range(0, 19) == 0), rdy);
        end

        // ---- asynchronous reset with three writes in flight ----
        apply_cycle("pre-rst flush", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1, rdy);
        apply_cycle("pre-rst a", 2'b11, 5'd21, 32'h21, 5'd22, 32'h22, 0, rdy);
        apply_cycle("pre-rst b", 2'b01, 5'd23, 32'h23, 5'd0, 32'h0, 0, rdy);
        check("pre-rst rf_we", rf_we, 1'b1);
        check("pre-rst rf_waddr", rf_waddr, 5'd21);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("async rst rf_we", rf_we, 1'b0);
        check("async rst pend_mask", pend_mask, 32'h0);
        check("async rst idle", idle, 1'b1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        writes = 0;
        for (int c = 0; c < 6; c++) begin
            apply_cycle("post-rst", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 0, rdy);
            if (rf_we) writes++;
        end
        check("post-rst writes", writes, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
